fpnew_result_fifo: RTL and testbench
====================================

Name: fpnew_result_fifo

Overview:
- Result buffer that sits directly downstream of the operation-unit output pipeline.
- It absorbs completed results (value, status flags, extension bit, tag, aux) behind a valid/ready handshake, so that downstream writeback stalls do not back-pressure in-flight operations immediately.
- It provides in-order buffering, an optional fall-through path, a synchronous flush, and occupancy/busy status for the top-level busy aggregation.

Parameters:
- Width, 32, result data width in bits.
- Depth, 2, number of entries; legal range 1..16; need not be a power of two.
- FallThrough, 0, 1 = an empty FIFO forwards the input combinationally to the output in the same cycle; 0 = minimum latency is 1 cycle.
- TagType, logic, type of the operation tag carried with each result.
- AuxType, logic, type of the auxiliary sideband carried with each result.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- result_i  in  Width  result value from the operation unit.
- status_i  in  5  fpnew_pkg::status_t flags {NV,DZ,OF,UF,NX}.
- extension_bit_i  in  1  NaN-boxing extension bit.
- tag_i  in  TagType  operation tag.
- aux_i  in  AuxType  sideband.
- in_valid_i  in  1  upstream result valid.
- in_ready_o  out  1  FIFO accepts an entry this cycle.
- flush_i  in  1  synchronous discard of all contents.
- result_o, status_o, extension_bit_o, tag_o, aux_o  out  as the inputs  head entry.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  downstream accepts the head entry.
- count_o  out  $clog2(Depth+1)  current occupancy.
- busy_o  out  1  any valid entry held, or a valid input present this cycle.

Behaviour:
- Reset (rst_i high, asynchronous): read and write pointers = 0, count = 0. out_valid_o = 0, count_o = 0, busy_o = in_valid_i, in_ready_o = 1.
- Storage array has no reset. Data outputs are don't-care while out_valid_o = 0; the bench must not check them in that state.
- Push = in_valid_i & in_ready_o. Pop = out_valid_o & out_ready_i. Both are evaluated on the same edge.
- in_ready_o = (count < Depth) & ~flush_i.
  - There is no combinational path from out_ready_i to in_ready_o.
  - When full, a simultaneous pop does not enable a push in that cycle.
- out_valid_o = (count > 0) & ~flush_i. When FallThrough = 1, out_valid_o also asserts if count == 0 & in_valid_i & ~flush_i.
- Fall-through (FallThrough = 1, count == 0):
  - Outputs mirror the inputs combinationally.
  - If out_ready_i is also high, the entry passes through and is not written; count stays 0.
  - If out_ready_i is low, the entry is written and count becomes 1.
- Non-fall-through: a pushed entry first appears at the output one cycle after the push. Latency through an empty FIFO is 1 cycle.
- Ordering: strict FIFO. Pointers increment modulo Depth and wrap from Depth-1 to 0 (explicit compare, not bit truncation).
- Count update per cycle: push & ~pop → +1; pop & ~push → -1; both → unchanged, pointers both advance.
- Flush (flush_i high at an edge):
  - pointers and count go to 0;
  - no push or pop occurs that cycle, because in_ready_o and out_valid_o are forced to 0 during flush;
  - flush takes priority over any handshake.
- Depth = 1: alternates full/empty. Maximum throughput is 1 entry per 2 cycles without fall-through, and 1 per cycle with fall-through when downstream is always ready.
- busy_o = (count != 0) | in_valid_i.
- Upstream protocol: payload is stable and in_valid_i is not withdrawn while in_valid_i & ~in_ready_o. A protocol assertion checks this in simulation.
- Output protocol guarantee: while out_valid_o & ~out_ready_i and no flush, head payload and out_valid_o are held stable.

Test Plan:
- Depth=2, FallThrough=0, out_ready_i=0; push results 0x3F800000 then 0x40000000 (tags 1, 2). Expect in_ready_o=0 after the 2nd push and count_o=2. Raise out_ready_i: outputs 0x3F800000/tag1, then 0x40000000/tag2, one per cycle; count returns to 0.
- Depth=3, continuous push and pop for 10 entries with tags 0..9. Expect in-order delivery and pointer wrap after entry 2. Each result appears exactly 1 cycle after its push.
- FallThrough=1, empty, out_ready_i=1, push 0xDEADBEEF with status 5'b00001. Expect out_valid_o=1 with the same data in the same cycle, and count_o stays 0.
- Fill Depth=2, then pulse flush_i with in_valid_i=1 in the same cycle. Expect in_ready_o=0 and out_valid_o=0 during the flush, then count_o=0 and no entry accepted.
- Assert rst_i mid-stream with count=2, asynchronously between edges. Expect out_valid_o=0 and count_o=0 immediately, in_ready_o=1, and normal operation after release.
- Depth=1, out_ready_i held 1, back-to-back inputs. Expect an accept on every other cycle, with in_ready_o low on each cycle where count=1.

Source files
------------

// File: rtl/fpnew_result_fifo.sv
// Purpose : in-order result buffer behind the operation-unit output pipeline.
// Latency : 1 cycle through an empty FIFO; 0 cycles when FallThrough = 1.
// Backpressure: in_ready_o depends only on occupancy and flush, never on out_ready_i.
//
// Ports:
//   clk_i, rst_i                      clock (rising edge), async active-high reset
//   result_i/status_i/extension_bit_i/tag_i/aux_i, in_valid_i, in_ready_o
//                                     upstream result entry and handshake
//   flush_i                           synchronous discard of all entries
//   result_o/status_o/extension_bit_o/tag_o/aux_o, out_valid_o, out_ready_i
//                                     head entry and downstream handshake
//   count_o, busy_o                   occupancy and busy status
module fpnew_result_fifo #(
  parameter int unsigned Width       = 32,
  parameter int unsigned Depth       = 2,
  parameter bit          FallThrough = 1'b0,
  parameter type         TagType     = logic,
  parameter type         AuxType     = logic
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [Width-1:0]             result_i,
  input  logic [4:0]                   status_i,
  input  logic                         extension_bit_i,
  input  TagType                       tag_i,
  input  AuxType                       aux_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic                         flush_i,
  output logic [Width-1:0]             result_o,
  output logic [4:0]                   status_o,
  output logic                         extension_bit_o,
  output TagType                       tag_o,
  output AuxType                       aux_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [$clog2(Depth+1)-1:0]   count_o,
  output logic                         busy_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  // A single-entry FIFO still needs a 1-bit pointer; it just never moves.
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);

  // Storage is not reset: contents are only observable once counted valid.
  logic [Width-1:0] result_q [Depth];
  logic [4:0]       status_q [Depth];
  logic             ext_q    [Depth];
  TagType           tag_q    [Depth];
  AuxType           aux_q    [Depth];

  logic [PtrW-1:0] rd_ptr, wr_ptr;
  logic [CntW-1:0] count;

  logic empty, pass_through, push, pop, write_en, read_en;

  // Depth need not be a power of two, so wrap on an explicit compare.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign empty        = (count == '0);
  assign pass_through = FallThrough & empty;

  assign in_ready_o  = (count < DepthCnt) & ~flush_i;
  assign out_valid_o = (~empty | (FallThrough & in_valid_i)) & ~flush_i;

  assign push = in_valid_i & in_ready_o;
  assign pop  = out_valid_o & out_ready_i;

  // In fall-through with a ready consumer the entry bypasses storage entirely;
  // in that case the pop consumes the bypassed entry, not the (empty) head.
  assign write_en = push & ~(pass_through & out_ready_i);
  assign read_en  = pop & ~pass_through;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (write_en) wr_ptr <= next_ptr(wr_ptr);
      if (read_en)  rd_ptr <= next_ptr(rd_ptr);
      if (write_en && !read_en)      count <= count + 1'b1;
      else if (read_en && !write_en) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (write_en) begin
      result_q[wr_ptr] <= result_i;
      status_q[wr_ptr] <= status_i;
      ext_q[wr_ptr]    <= extension_bit_i;
      tag_q[wr_ptr]    <= tag_i;
      aux_q[wr_ptr]    <= aux_i;
    end
  end

  always_comb begin
    result_o        = result_q[rd_ptr];
    status_o        = status_q[rd_ptr];
    extension_bit_o = ext_q[rd_ptr];
    tag_o           = tag_q[rd_ptr];
    aux_o           = aux_q[rd_ptr];
    if (pass_through) begin
      result_o        = result_i;
      status_o        = status_i;
      extension_bit_o = extension_bit_i;
      tag_o           = tag_i;
      aux_o           = aux_i;
    end
  end

  assign count_o = count;
  assign busy_o  = ~empty | in_valid_i;

`ifndef SYNTHESIS
  // Upstream must hold a stalled entry stable; a flush releases it from that duty.
  a_in_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (in_valid_i & ~in_ready_o & ~flush_i) |=>
      (in_valid_i && $stable(result_i) && $stable(status_i) &&
       $stable(extension_bit_i) && $stable(tag_i) && $stable(aux_i)))
    else $error("upstream entry changed while stalled");
`endif

endmodule

// File: tb/tb_fpnew_result_fifo.sv
module tb_fpnew_result_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] res_i = '0;
  logic [4:0]  st_i  = '0;
  logic        ext_i = 1'b0;
  logic [3:0]  tag_i = '0;
  logic [7:0]  aux_i = '0;
  logic        flush = 1'b0;
  logic        ordy  = 1'b0;
  logic        vld [4];

  logic [31:0] o_res [4];
  logic [4:0]  o_st  [4];
  logic        o_ext [4];
  logic [3:0]  o_tag [4];
  logic [7:0]  o_aux [4];
  logic        o_vld [4];
  logic        i_rdy [4];
  logic        o_busy[4];
  logic [1:0]  cnt_a, cnt_b, cnt_c;
  logic [0:0]  cnt_d;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // a: Depth 2, registered   b: Depth 3, registered
  // c: Depth 2, fall-through d: Depth 1, registered
  fpnew_result_fifo #(.Width(32), .Depth(2), .FallThrough(1'b0),
                      .TagType(logic [3:0]), .AuxType(logic [7:0])) u_a (
    .clk_i(clk), .rst_i(rst), .result_i(res_i), .status_i(st_i),
    .extension_bit_i(ext_i), .tag_i(tag_i), .aux_i(aux_i),
    .in_valid_i(vld[0]), .in_ready_o(i_rdy[0]), .flush_i(flush),
    .result_o(o_res[0]), .status_o(o_st[0]), .extension_bit_o(o_ext[0]),
    .tag_o(o_tag[0]), .aux_o(o_aux[0]), .out_valid_o(o_vld[0]),
    .out_ready_i(ordy), .count_o(cnt_a), .busy_o(o_busy[0]));

  fpnew_result_fifo #(.Width(32), .Depth(3), .FallThrough(1'b0),
                      .TagType(logic [3:0]), .AuxType(logic [7:0])) u_b (
    .clk_i(clk), .rst_i(rst), .result_i(res_i), .status_i(st_i),
    .extension_bit_i(ext_i), .tag_i(tag_i), .aux_i(aux_i),
    .in_valid_i(vld[1]), .in_ready_o(i_rdy[1]), .flush_i(flush),
    .result_o(o_res[1]), .status_o(o_st[1]), .extension_bit_o(o_ext[1]),
    .tag_o(o_tag[1]), .aux_o(o_aux[1]), .out_valid_o(o_vld[1]),
    .out_ready_i(ordy), .count_o(cnt_b), .busy_o(o_busy[1]));

  fpnew_result_fifo #(.Width(32), .Depth(2), .FallThrough(1'b1),
                      .TagType(logic [3:0]), .AuxType(logic [7:0])) u_c (
    .clk_i(clk), .rst_i(rst), .result_i(res_i), .status_i(st_i),
    .extension_bit_i(ext_i), .tag_i(tag_i), .aux_i(aux_i),
    .in_valid_i(vld[2]), .in_ready_o(i_rdy[2]), .flush_i(flush),
    .result_o(o_res[2]), .status_o(o_st[2]), .extension_bit_o(o_ext[2]),
    .tag_o(o_tag[2]), .aux_o(o_aux[2]), .out_valid_o(o_vld[2]),
    .out_ready_i(ordy), .count_o(cnt_c), .busy_o(o_busy[2]));

  fpnew_result_fifo #(.Width(32), .Depth(1), .FallThrough(1'b0),
                      .TagType(logic [3:0]), .AuxType(logic [7:0])) u_d (
    .clk_i(clk), .rst_i(rst), .result_i(res_i), .status_i(st_i),
    .extension_bit_i(ext_i), .tag_i(tag_i), .aux_i(aux_i),
    .in_valid_i(vld[3]), .in_ready_o(i_rdy[3]), .flush_i(flush),
    .result_o(o_res[3]), .status_o(o_st[3]), .extension_bit_o(o_ext[3]),
    .tag_o(o_tag[3]), .aux_o(o_aux[3]), .out_valid_o(o_vld[3]),
    .out_ready_i(ordy), .count_o(cnt_d), .busy_o(o_busy[3]));

  typedef struct packed {
    logic        vld;
    logic [31:0] res;
    logic [3:0]  tag;
    logic        ordy;
    logic        flush;
    logic        e_rdy;
    logic        e_vld;
    logic [1:0]  e_cnt;
    logic        e_busy;
    logic [31:0] e_res;
    logic [3:0]  e_tag;
  } vec_t;

  vec_t tv [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] r, input logic [3:0] t);
    res_i = r;
    tag_i = t;
    st_i  = {1'b0, t};
    ext_i = t[0];
    aux_i = {4'hA, t};
  endtask

  task automatic do_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) vld[i] = 1'b0;
    flush = 1'b0;
    ordy  = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    //          vld res           tag  ordy flush | rdy vld cnt busy e_res         e_tag
    tv[0]  = '{1'b1, 32'h3F800000, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h0,        4'd0};
    tv[1]  = '{1'b1, 32'h40000000, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 32'h3F800000, 4'd1};
    tv[2]  = '{1'b0, 32'h0,        4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 32'h3F800000, 4'd1};
    tv[3]  = '{1'b0, 32'h0,        4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 32'h3F800000, 4'd1};
    tv[4]  = '{1'b0, 32'h0,        4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 32'h40000000, 4'd2};
    tv[5]  = '{1'b0, 32'h0,        4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0,        4'd0};
    tv[6]  = '{1'b1, 32'hAAAA0003, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h0,        4'd0};
    tv[7]  = '{1'b1, 32'hBBBB0004, 4'd4, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 32'hAAAA0003, 4'd3};
    tv[8]  = '{1'b1, 32'hCCCC0005, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 32'h0,        4'd0};
    tv[9]  = '{1'b0, 32'h0,        4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0,        4'd0};
    tv[10] = '{1'b1, 32'hDDDD0006, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h0,        4'd0};
    tv[11] = '{1'b1, 32'hEEEE0007, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 32'h0,        4'd0};
    tv[12] = '{1'b0, 32'h0,        4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0,        4'd0};
    tv[13] = '{1'b1, 32'h11110008, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h0,        4'd0};
    tv[14] = '{1'b1, 32'h22220009, 4'd9, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 32'h11110008, 4'd8};
    tv[15] = '{1'b0, 32'h0,        4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 32'h22220009, 4'd9};
    tv[16] = '{1'b0, 32'h0,        4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0,        4'd0};

    for (int i = 0; i < 4; i++) vld[i] = 1'b0;

    // Reset state of every instance, and busy following in_valid during reset.
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst%0d_rdy", i), i_rdy[i], 1);
      chk($sformatf("rst%0d_vld", i), o_vld[i], 0);
      chk($sformatf("rst%0d_busy", i), o_busy[i], 0);
    end
    chk("rst_cnt_a", cnt_a, 0);
    chk("rst_cnt_b", cnt_b, 0);
    chk("rst_cnt_c", cnt_c, 0);
    chk("rst_cnt_d", cnt_d, 0);
    vld[1] = 1'b1;
    #1;
    chk("rst_busy_in", o_busy[1], 1);
    vld[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Table: Depth 2 stall/drain, flush when full and when partly full, push+pop.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      vld[0] = tv[i].vld;
      drive(tv[i].res, tv[i].tag);
      ordy  = tv[i].ordy;
      flush = tv[i].flush;
      #2;
      chk($sformatf("v%0d_rdy", i), i_rdy[0], tv[i].e_rdy);
      chk($sformatf("v%0d_vld", i), o_vld[0], tv[i].e_vld);
      chk($sformatf("v%0d_cnt", i), cnt_a, tv[i].e_cnt);
      chk($sformatf("v%0d_busy", i), o_busy[0], tv[i].e_busy);
      if (tv[i].e_vld) begin
        chk($sformatf("v%0d_res", i), o_res[0], tv[i].e_res);
        chk($sformatf("v%0d_tag", i), o_tag[0], tv[i].e_tag);
        chk($sformatf("v%0d_st", i), o_st[0], {1'b0, tv[i].e_tag});
        chk($sformatf("v%0d_ext", i), o_ext[0], tv[i].e_tag[0]);
        chk($sformatf("v%0d_aux", i), o_aux[0], {4'hA, tv[i].e_tag});
      end
    end
    @(negedge clk);
    vld[0] = 1'b0;
    flush  = 1'b0;

    // Depth 3 streaming: ten entries, pointer wrap, one-cycle latency each.
    do_reset();
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      vld[1] = (k < 10);
      drive(32'h100 + k, k[3:0]);
      ordy = 1'b1;
      #2;
      chk($sformatf("s%0d_rdy", k), i_rdy[1], 1);
      if (k == 0) begin
        chk("s0_vld", o_vld[1], 0);
        chk("s0_cnt", cnt_b, 0);
      end else begin
        chk($sformatf("s%0d_vld", k), o_vld[1], 1);
        chk($sformatf("s%0d_res", k), o_res[1], 32'h100 + k - 1);
        chk($sformatf("s%0d_tag", k), o_tag[1], 32'(k - 1));
        chk($sformatf("s%0d_cnt", k), cnt_b, (k < 10) ? 1 : 1);
      end
    end
    @(negedge clk);
    vld[1] = 1'b0;
    #2;
    chk("s_end_vld", o_vld[1], 0);
    chk("s_end_cnt", cnt_b, 0);

    // Fall-through: ready consumer sees the entry in the same cycle, nothing stored.
    do_reset();
    @(negedge clk);
    vld[2] = 1'b1;
    res_i = 32'hDEADBEEF; st_i = 5'b00001; ext_i = 1'b1; tag_i = 4'd5; aux_i = 8'h55;
    ordy = 1'b1;
    #2;
    chk("ft_vld", o_vld[2], 1);
    chk("ft_res", o_res[2], 32'hDEADBEEF);
    chk("ft_st", o_st[2], 5'b00001);
    chk("ft_tag", o_tag[2], 4'd5);
    chk("ft_aux", o_aux[2], 8'h55);
    chk("ft_cnt", cnt_c, 0);
    @(negedge clk);
    vld[2] = 1'b0;
    #2;
    chk("ft_cnt_after", cnt_c, 0);
    chk("ft_vld_after", o_vld[2], 0);
    chk("ft_busy_after", o_busy[2], 0);
    // Fall-through with a stalled consumer: entry is shown and also stored.
    @(negedge clk);
    vld[2] = 1'b1;
    res_i = 32'hCAFEF00D; st_i = 5'b10000; ext_i = 1'b0; tag_i = 4'd6; aux_i = 8'h66;
    ordy = 1'b0;
    #2;
    chk("fts_vld", o_vld[2], 1);
    chk("fts_res", o_res[2], 32'hCAFEF00D);
    @(negedge clk);
    vld[2] = 1'b0;
    res_i = 32'h0; st_i = 5'b0; tag_i = 4'd0;
    #2;
    chk("fts_cnt", cnt_c, 1);
    chk("fts_hold_res", o_res[2], 32'hCAFEF00D);
    chk("fts_hold_st", o_st[2], 5'b10000);
    chk("fts_hold_tag", o_tag[2], 4'd6);
    ordy = 1'b1;
    @(negedge clk);
    #2;
    chk("fts_drained", cnt_c, 0);
    chk("fts_drained_vld", o_vld[2], 0);

    // Asynchronous reset mid-stream with two entries held.
    do_reset();
    @(negedge clk);
    vld[0] = 1'b1;
    drive(32'h55550001, 4'd1);
    @(negedge clk);
    drive(32'h55550002, 4'd2);
    @(negedge clk);
    vld[0] = 1'b0;
    #2;
    chk("ar_cnt_pre", cnt_a, 2);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_vld", o_vld[0], 0);
    chk("ar_cnt", cnt_a, 0);
    chk("ar_rdy", i_rdy[0], 1);
    chk("ar_busy", o_busy[0], 0);
    vld[0] = 1'b1;
    #1;
    chk("ar_busy_in", o_busy[0], 1);
    vld[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vld[0] = 1'b1;
    drive(32'h77770003, 4'd3);
    @(negedge clk);
    vld[0] = 1'b0;
    #2;
    chk("ar_post_vld", o_vld[0], 1);
    chk("ar_post_res", o_res[0], 32'h77770003);
    chk("ar_post_cnt", cnt_a, 1);
    ordy = 1'b1;
    @(negedge clk);
    #2;
    chk("ar_post_drain", cnt_a, 0);

    // Depth 1 with an always-ready consumer: one accept every other cycle.
    do_reset();
    begin
      int idx;
      idx = 0;
      ordy = 1'b1;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        vld[3] = 1'b1;
        drive(32'h200 + idx, idx[3:0]);
        #2;
        chk($sformatf("d1_%0d_rdy", c), i_rdy[3], (c % 2 == 0));
        chk($sformatf("d1_%0d_cnt", c), cnt_d, (c % 2));
        if (c % 2 == 1) begin
          chk($sformatf("d1_%0d_vld", c), o_vld[3], 1);
          chk($sformatf("d1_%0d_res", c), o_res[3], 32'h200 + c / 2);
        end
        if (i_rdy[3]) idx++;
      end
      @(negedge clk);
      vld[3] = 1'b0;
      #2;
      chk("d1_accepts", idx, 4);
      chk("d1_end_cnt", cnt_d, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
